// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
//
// Top-level drawing controller. On a start request it latches the triangle
// parameters, clears the whole frame to BG_COLOUR (column-major scan), then
// holds rl_start high to the reuleaux drawer and forwards its pixel stream to
// the VGA adapter until rl_done. Completion is reported with a level
// start/done handshake: done stays high until the requester drops start.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   start                      level request, held until done is seen
//   colour/centre_x/centre_y/diameter   triangle parameters, latched on accept
//   done                       high while in DONE
//   rl_start, rl_colour, rl_centre_x, rl_centre_y, rl_diameter
//                              request and latched parameters to reuleaux
//   rl_done                    completion from reuleaux
//   rl_vga_x/y/colour/plot     reuleaux pixel stream
//   vga_x/y/colour/plot        muxed pixel stream to the VGA adapter
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; nothing plotted
// S_CLEAR | plotting BG_COLOUR at (cx,cy), one pixel per cycle
// S_DRAW  | rl_start high; rl_vga_* forwarded to the VGA port
// S_DONE  | done high; waiting for start to drop
// -----------------------------------------------------------------------------
module draw_sequencer #(
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] colour,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] diameter,
   output logic       done,
   output logic       rl_start,
   output logic [2:0] rl_colour,
   output logic [7:0] rl_centre_x,
   output logic [6:0] rl_centre_y,
   output logic [7:0] rl_diameter,
   input  logic       rl_done,
   input  logic [7:0] rl_vga_x,
   input  logic [6:0] rl_vga_y,
   input  logic [2:0] rl_vga_colour,
   input  logic       rl_vga_plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic [2:0] colour_q, colour_d;
   logic [7:0] centre_x_q, centre_x_d;
   logic [6:0] centre_y_q, centre_y_d;
   logic [7:0] diameter_q, diameter_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cx_q       <= '0;
         cy_q       <= '0;
         colour_q   <= '0;
         centre_x_q <= '0;
         centre_y_q <= '0;
         diameter_q <= '0;
      end else begin
         state_q    <= state_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         colour_q   <= colour_d;
         centre_x_q <= centre_x_d;
         centre_y_q <= centre_y_d;
         diameter_q <= diameter_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      colour_d   = colour_q;
      centre_x_d = centre_x_q;
      centre_y_d = centre_y_q;
      diameter_d = diameter_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               colour_d   = colour;
               centre_x_d = centre_x;
               centre_y_d = centre_y;
               diameter_d = diameter;
               cx_d       = '0;
               cy_d       = '0;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            // Column-major: y runs fastest, x steps on y wrap.
            if (cy_q == CY_LAST) begin
               cy_d = '0;
               if (cx_q == CX_LAST) begin
                  cx_d    = '0;
                  state_d = S_DRAW;
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end else begin
               cy_d = cy_q + 7'd1;
            end
         end
         S_DRAW: begin
            if (rl_done) state_d = S_DONE;
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      done       = 1'b0;
      rl_start   = 1'b0;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      case (state_q)
         S_CLEAR: begin
            vga_x      = cx_q;
            vga_y      = cy_q;
            vga_colour = BG_COLOUR;
            vga_plot   = 1'b1;
         end
         S_DRAW: begin
            rl_start   = 1'b1;
            vga_x      = rl_vga_x;
            vga_y      = rl_vga_y;
            vga_colour = rl_vga_colour;
            vga_plot   = rl_vga_plot;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign rl_colour   = colour_q;
   assign rl_centre_x = centre_x_q;
   assign rl_centre_y = centre_y_q;
   assign rl_diameter = diameter_q;

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] colour;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] diameter;
   logic       done;
   logic       rl_start;
   logic [2:0] rl_colour;
   logic [7:0] rl_centre_x;
   logic [6:0] rl_centre_y;
   logic [7:0] rl_diameter;
   logic       rl_done;
   logic [7:0] rl_vga_x;
   logic [6:0] rl_vga_y;
   logic [2:0] rl_vga_colour;
   logic       rl_vga_plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   draw_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
      .done(done), .rl_start(rl_start),
      .rl_colour(rl_colour), .rl_centre_x(rl_centre_x),
      .rl_centre_y(rl_centre_y), .rl_diameter(rl_diameter),
      .rl_done(rl_done),
      .rl_vga_x(rl_vga_x), .rl_vga_y(rl_vga_y),
      .rl_vga_colour(rl_vga_colour), .rl_vga_plot(rl_vga_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push_clear();
      for (int x = 0; x < 160; x++)
         for (int y = 0; y < 120; y++)
            exp_q.push_back('{x: 8'(x), y: 7'(y), c: 3'b000});
   endtask

   task automatic push_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      exp_q.push_back('{x: x, y: y, c: c});
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_rl_start"}, 32'(rl_start), 0);
      chk({tag, "_vga_plot"}, 32'(vga_plot), 0);
   endtask

   task automatic chk_params(input string tag, input logic [2:0] c, input logic [7:0] x,
                             input logic [6:0] y, input logic [7:0] d);
      chk({tag, "_rl_colour"}, 32'(rl_colour), 32'(c));
      chk({tag, "_rl_centre_x"}, 32'(rl_centre_x), 32'(x));
      chk({tag, "_rl_centre_y"}, 32'(rl_centre_y), 32'(y));
      chk({tag, "_rl_diameter"}, 32'(rl_diameter), 32'(d));
   endtask

   // Monitor: every plotted pixel must be the next expected one.
   initial begin
      pix_t e;
      forever begin
         @(negedge clk);
         if (vga_plot === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_plot: got (%0d,%0d,c=%0d), expected no plot",
                        vga_x, vga_y, vga_colour);
            end else begin
               e = exp_q.pop_front();
               if (vga_x === e.x && vga_y === e.y && vga_colour === e.c) n_pass++;
               else $display("FAIL pixel: got (%0d,%0d,c=%0d), expected (%0d,%0d,c=%0d)",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0;
      colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
      rl_done = 1'b0; rl_vga_x = '0; rl_vga_y = '0; rl_vga_colour = '0; rl_vga_plot = 1'b0;

      // Reset and idle
      #1;
      chk_quiet("reset");
      chk("reset_vga_x", 32'(vga_x), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk_quiet("idle");
      end

      // Run 1: full clear, parameter change mid-clear, pass-through, handshake
      colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80;
      push_clear();
      start = 1'b1;
      @(posedge clk); #1;
      repeat (100) @(posedge clk);
      #1 colour = 3'b001; centre_x = 8'd10; centre_y = 7'd10; diameter = 8'd20;
      repeat (19099) @(posedge clk);
      #1 chk("r1_rl_start_before_last", 32'(rl_start), 0);
      @(posedge clk); #1;
      chk("r1_rl_start_after_clear", 32'(rl_start), 1);
      chk("r1_clear_drained", 32'(exp_q.size()), 0);
      chk_params("r1", 3'b010, 8'd80, 7'd60, 8'd80);

      push_pix(8'd95, 7'd40, 3'b010);
      rl_vga_x = 8'd95; rl_vga_y = 7'd40; rl_vga_colour = 3'b010; rl_vga_plot = 1'b1;
      #1;
      chk("pass_x", 32'(vga_x), 95);
      chk("pass_y", 32'(vga_y), 40);
      chk("pass_colour", 32'(vga_colour), 2);
      chk("pass_plot", 32'(vga_plot), 1);
      @(posedge clk); #1;
      push_pix(8'd159, 7'd119, 3'b111);
      rl_vga_x = 8'd159; rl_vga_y = 7'd119; rl_vga_colour = 3'b111;
      @(posedge clk); #1;
      rl_vga_plot = 1'b0;
      @(posedge clk); #1;
      chk("r1_draw_drained", 32'(exp_q.size()), 0);

      rl_done = 1'b1;
      @(posedge clk); #1;
      rl_done = 1'b0;
      rl_vga_plot = 1'b1;  // must not leak through outside DRAW
      chk("r1_done", 32'(done), 1);
      chk("r1_done_rl_start", 32'(rl_start), 0);
      chk("r1_done_vga_plot", 32'(vga_plot), 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("r1_done_held", 32'(done), 1);
      end
      start = 1'b0;
      @(posedge clk); #1;
      rl_vga_plot = 1'b0;
      chk_quiet("r1_back_idle");
      repeat (3) @(posedge clk);
      #1 chk_quiet("r1_idle_stays");

      // Run 2: start pulsed for one cycle only; block still completes
      colour = 3'b101; centre_x = 8'd33; centre_y = 7'd22; diameter = 8'd44;
      push_clear();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19199) @(posedge clk);
      #1 chk("r2_rl_start_before_last", 32'(rl_start), 0);
      @(posedge clk); #1;
      chk("r2_rl_start_after_clear", 32'(rl_start), 1);
      chk("r2_clear_drained", 32'(exp_q.size()), 0);
      chk_params("r2", 3'b101, 8'd33, 7'd22, 8'd44);
      rl_done = 1'b1;
      @(posedge clk); #1;
      rl_done = 1'b0;
      chk("r2_done_one_cycle", 32'(done), 1);
      @(posedge clk); #1;
      chk_quiet("r2_back_idle");

      // Run 3: reset at clear pixel 5000, then restart from (0,0)
      colour = 3'b011; centre_x = 8'd100; centre_y = 7'd50; diameter = 8'd30;
      push_clear();
      start = 1'b1;
      @(posedge clk); #1;
      repeat (5000) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk_quiet("midreset");
      chk("midreset_vga_x", 32'(vga_x), 0);
      chk("midreset_vga_y", 32'(vga_y), 0);
      chk("midreset_vga_colour", 32'(vga_colour), 0);
      repeat (2) @(posedge clk);
      push_clear();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (19199) @(posedge clk);
      #1 chk("r3_rl_start_before_last", 32'(rl_start), 0);
      @(posedge clk); #1;
      chk("r3_rl_start_after_clear", 32'(rl_start), 1);
      chk("r3_clear_drained", 32'(exp_q.size()), 0);
      chk_params("r3", 3'b011, 8'd100, 7'd50, 8'd30);
      rl_done = 1'b1;
      @(posedge clk); #1;
      rl_done = 1'b0;
      chk("r3_done", 32'(done), 1);
      start = 1'b0;
      @(posedge clk); #1;
      chk_quiet("r3_back_idle");
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
